// File: rtl/sclk_tick_rx.sv
// Brings a slow sclk into the clk domain as single-cycle enable ticks, measures its period
// and tracks lock/loss. Define SCLK_RX_FALL_MEAS_EN to add fall ticks and high-time measurement.
module sclk_tick_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 24,
  parameter int TIMEOUT     = 250000,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);
  localparam int                 MATCH_W     = $clog2(LOCK_COUNT + 1);
  localparam int                 DIFF_W      = CNT_W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]   CNT_TIMEOUT = CNT_W'(TIMEOUT - 1);
  localparam logic [MATCH_W-1:0] MATCH_LOCK  = MATCH_W'(LOCK_COUNT);
  localparam logic [DIFF_W-1:0]  TOL_W       = DIFF_W'(TOL);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED, ST_LOST} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise_tick;
  logic [CNT_W-1:0]       r_cnt;
  state_t                 r_state,       w_state_next;
  logic [MATCH_W-1:0]     r_match_cnt,   w_match_next;
  logic [CNT_W-1:0]       r_prev_period, w_prev_period_next;
  logic [CNT_W-1:0]       r_period,      w_period_next;
  logic                   r_have_prev,   w_have_prev_next;
  logic                   r_valid,       w_valid_next;
  logic                   r_locked,      w_locked_next;
  logic                   r_lost,        w_lost_next;

  logic                   w_sync;
  logic                   w_rise;
  logic                   w_timeout;
  logic                   w_match;
  logic [CNT_W-1:0]       w_p;
  logic [DIFF_W-1:0]      w_diff;
  logic [MATCH_W-1:0]     w_match_inc;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_sync & ~r_prev;
  assign w_timeout   = (r_cnt == CNT_TIMEOUT);
  // A saturated counter reports the saturated value rather than wrapping to zero.
  assign w_p         = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
  assign w_diff      = (w_p >= r_prev_period) ? ({1'b0, w_p} - {1'b0, r_prev_period})
                                              : ({1'b0, r_prev_period} - {1'b0, w_p});
  assign w_match     = r_have_prev && (w_diff <= TOL_W);
  assign w_match_inc = r_match_cnt + 1'b1;

  // NOTE: the synchronizer chain and every control register are reset so no stale
  // level can produce a tick or a bogus period right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync        <= '0;
      r_prev        <= 1'b0;
      r_rise_tick   <= 1'b0;
      r_cnt         <= '0;
      r_state       <= ST_IDLE;
      r_match_cnt   <= '0;
      r_prev_period <= '0;
      r_period      <= '0;
      r_have_prev   <= 1'b0;
      r_valid       <= 1'b0;
      r_locked      <= 1'b0;
      r_lost        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_sync        <= {r_sync[SYNC_STAGES-2:0], sclk_in};
      r_prev        <= w_sync;
      r_rise_tick   <= w_rise;
      r_cnt         <= w_rise ? '0 : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1);
      r_state       <= w_state_next;
      r_match_cnt   <= w_match_next;
      r_prev_period <= w_prev_period_next;
      r_period      <= w_period_next;
      r_have_prev   <= w_have_prev_next;
      r_valid       <= w_valid_next;
      r_locked      <= w_locked_next;
      r_lost        <= w_lost_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no latch is inferred.
    w_state_next       = r_state;
    w_match_next       = r_match_cnt;
    w_prev_period_next = r_prev_period;
    w_period_next      = r_period;
    w_have_prev_next   = r_have_prev;
    w_valid_next       = r_valid;
    w_locked_next      = r_locked;
    w_lost_next        = r_lost;

    unique case (r_state)
      ST_IDLE, ST_LOST: begin
        if (w_rise) begin
          w_state_next     = ST_ACQUIRE;
          w_match_next     = '0;
          w_have_prev_next = 1'b0;
        end
      end
      ST_ACQUIRE, ST_LOCKED: begin
        if (w_rise) begin
          w_period_next      = w_p;
          w_valid_next       = 1'b1;
          w_prev_period_next = w_p;
          w_have_prev_next   = 1'b1;
          if (!w_match) begin
            w_match_next  = '0;
            w_locked_next = 1'b0;
            w_state_next  = ST_ACQUIRE;
          end else if (r_state == ST_ACQUIRE) begin
            w_match_next = w_match_inc;
            if (w_match_inc == MATCH_LOCK) begin
              w_state_next  = ST_LOCKED;
              w_locked_next = 1'b1;
              w_lost_next   = 1'b0;
            end
          end
        end else if (w_timeout) begin
          w_state_next     = ST_LOST;
          w_lost_next      = 1'b1;
          w_locked_next    = 1'b0;
          w_valid_next     = 1'b0;
          w_match_next     = '0;
          w_have_prev_next = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rise_tick    = r_rise_tick;
  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign lost         = r_lost;

`ifdef SCLK_RX_FALL_MEAS_EN
  logic             w_fall;
  logic             r_fall_tick;
  logic             r_seen_rise;
  logic [CNT_W-1:0] r_high_time;

  assign w_fall = ~w_sync & r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fall_tick <= 1'b0;
      r_seen_rise <= 1'b0;
      r_high_time <= '0;
    end else begin
      r_fall_tick <= w_fall;
      if (w_rise)
        r_seen_rise <= 1'b1;
      else if (w_state_next == ST_LOST)
        r_seen_rise <= 1'b0;
      if (w_fall && r_seen_rise)
        r_high_time <= w_p;
    end
  end

  assign fall_tick = r_fall_tick;
  assign high_time = r_high_time;
`else
  assign fall_tick = 1'b0;
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_sclk_tick_rx.sv
// Directed bench for sclk_tick_rx: one instance with TIMEOUT=100, one with TIMEOUT=20,
// both fed from the same sclk so the rise/timeout tie can be observed alongside.
module tb_sclk_tick_rx;
  localparam int CNT_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             sclk;

  logic             rise_a, fall_a, valid_a, locked_a, lost_a;
  logic [CNT_W-1:0] period_a, high_a;
  logic             rise_b, fall_b, valid_b, locked_b, lost_b;
  logic [CNT_W-1:0] period_b, high_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-period observations, captured at the rise_tick slot (step 2 of each period).
  logic             o_rise, o_valid, o_locked, o_lost, o_locked_b;
  logic [CNT_W-1:0] o_period, o_high;
  int               o_nrise, o_nfall, o_lost_b_seen;

  sclk_tick_rx #(.TIMEOUT(100)) u_dut_a (
    .clk(clk), .rst(rst), .sclk_in(sclk),
    .rise_tick(rise_a), .fall_tick(fall_a), .period(period_a), .high_time(high_a),
    .period_valid(valid_a), .locked(locked_a), .lost(lost_a)
  );

  sclk_tick_rx #(.TIMEOUT(20)) u_dut_b (
    .clk(clk), .rst(rst), .sclk_in(sclk),
    .rise_tick(rise_b), .fall_tick(fall_b), .period(period_b), .high_time(high_b),
    .period_valid(valid_b), .locked(locked_b), .lost(lost_b)
  );

  always #5 clk = ~clk;

  task automatic step(input logic lvl);
    sclk = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int len, input int hi);
    o_nrise = 0;
    o_nfall = 0;
    o_lost_b_seen = 0;
    for (int i = 0; i < len; i++) begin
      step(i < hi);
      if (rise_a) o_nrise++;
      if (fall_a) o_nfall++;
      if (lost_b) o_lost_b_seen++;
      if (i == 2) begin
        o_rise     = rise_a;
        o_period   = period_a;
        o_valid    = valid_a;
        o_locked   = locked_a;
        o_lost     = lost_a;
        o_locked_b = locked_b;
      end
    end
    o_high = high_a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step(1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0);
  endtask

  task automatic test_reset();
    logic [2*(5+2*CNT_W)-1:0] obs;
    do_reset();
    repeat (7) drive_period(20, 10);
    n_tests++;
    if (locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prelock: locked=%0b expected 1", locked_a);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(i % 2 == 0);
      obs = {rise_a, fall_a, valid_a, locked_a, lost_a, period_a, high_a,
             rise_b, fall_b, valid_b, locked_b, lost_b, period_b, high_b};
      n_tests++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h expected 0", i, obs);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      n_tests++;
      if ({rise_a, rise_b} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_no_tick[%0d]: got %b expected 00", i, {rise_a, rise_b});
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      drive_period(20, 10);
      n_tests++;
      if ({o_rise, o_nrise} !== {1'b1, 32'd1}) begin
        n_fail++;
        $display("FAIL lock_tick k=%0d: at_slot=%0b count=%0d expected 1/1", k, o_rise, o_nrise);
      end
      n_tests++;
      if ({o_valid, o_period} !== {(k >= 2), CNT_W'((k >= 2) ? 20 : 0)}) begin
        n_fail++;
        $display("FAIL lock_period k=%0d: valid=%0b period=%0d expected %0b/%0d",
                 k, o_valid, o_period, (k >= 2), (k >= 2) ? 20 : 0);
      end
      n_tests++;
      if ({o_locked, o_lost} !== {(k >= 6), 1'b0}) begin
        n_fail++;
        $display("FAIL lock_state k=%0d: locked=%0b lost=%0b expected %0b/0", k, o_locked, o_lost, (k >= 6));
      end
    end
  endtask

  task automatic test_jitter();
    int lens[14]     = '{20, 22, 20, 22, 20, 22, 20, 30, 20, 20, 20, 20, 20, 20};
    int exp_lock[14] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    int exp_per;
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      drive_period(lens[k-1], 10);
      exp_per = (k >= 2) ? lens[k-2] : 0;
      n_tests++;
      if (o_locked !== exp_lock[k-1][0]) begin
        n_fail++;
        $display("FAIL jitter_locked k=%0d: got %0b expected %0d", k, o_locked, exp_lock[k-1]);
      end
      n_tests++;
      if (o_period !== CNT_W'(exp_per)) begin
        n_fail++;
        $display("FAIL jitter_period k=%0d: got %0d expected %0d", k, o_period, exp_per);
      end
    end
  endtask

  task automatic test_loss();
    int early = 0;
    do_reset();
    for (int k = 1; k <= 6; k++) drive_period(20, 10);
    n_tests++;
    if (o_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_prelock: locked=%0b expected 1", o_locked);
    end
    // rise_tick was at index 2 of the last period; lost is due at index 102.
    for (int i = 20; i < 102; i++) begin
      step(1'b0);
      if (lost_a) early++;
    end
    n_tests++;
    if ({early, locked_a} !== {32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL loss_early: lost cycles=%0d locked=%0b expected 0/1", early, locked_a);
    end
    step(1'b0);
    n_tests++;
    if ({lost_a, locked_a, valid_a} !== 3'b100) begin
      n_fail++;
      $display("FAIL loss_at_timeout: lost/locked/valid=%b expected 100", {lost_a, locked_a, valid_a});
    end
    n_tests++;
    if ({lost_b, locked_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL loss_short_timeout: lost/locked=%b expected 10", {lost_b, locked_b});
    end
    for (int k = 1; k <= 6; k++) begin
      drive_period(20, 10);
      n_tests++;
      if ({o_lost, o_locked} !== {(k < 6), (k == 6)}) begin
        n_fail++;
        $display("FAIL loss_recover k=%0d: lost=%0b locked=%0b expected %0b/%0b",
                 k, o_lost, o_locked, (k < 6), (k == 6));
      end
      if (k >= 2) begin
        n_tests++;
        if ({o_valid, o_period} !== {1'b1, CNT_W'(20)}) begin
          n_fail++;
          $display("FAIL loss_period k=%0d: valid=%0b period=%0d expected 1/20", k, o_valid, o_period);
        end
      end
    end
  endtask

  task automatic test_timeout_tie();
    int lost_total = 0;
    do_reset();
    // Long idle low: the IDLE state must not time out even though cnt passes TIMEOUT-1.
    repeat (25) begin
      step(1'b0);
      if (lost_b) lost_total++;
    end
    for (int k = 1; k <= 7; k++) begin
      drive_period(20, 10);
      lost_total += o_lost_b_seen;
      n_tests++;
      if ({lost_total, o_locked_b} !== {32'd0, (k >= 6)}) begin
        n_fail++;
        $display("FAIL tie k=%0d: lost cycles=%0d locked=%0b expected 0/%0b", k, lost_total, o_locked_b, (k >= 6));
      end
    end
  endtask

  task automatic test_fall();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive_period(20, 7);
`ifdef SCLK_RX_FALL_MEAS_EN
      n_tests++;
      if ({o_nfall, o_high} !== {32'd1, CNT_W'(7)}) begin
        n_fail++;
        $display("FAIL fall_meas k=%0d: falls=%0d high_time=%0d expected 1/7", k, o_nfall, o_high);
      end
`else
      n_tests++;
      if ({o_nfall, o_high} !== {32'd0, CNT_W'(0)}) begin
        n_fail++;
        $display("FAIL fall_off k=%0d: falls=%0d high_time=%0d expected 0/0", k, o_nfall, o_high);
      end
`endif
      n_tests++;
      if (o_nrise !== 1) begin
        n_fail++;
        $display("FAIL fall_rise_count k=%0d: got %0d expected 1", k, o_nrise);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    test_reset();
    test_lock();
    test_jitter();
    test_loss();
    test_timeout_tie();
    test_fall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
